// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the matrix result path.
package matrix_pkg;

    localparam int MTX_DW    = 16;
    localparam int MTX_LANES = 4;
    localparam int MTX_WORDS = 16;
    localparam int MTX_AW    = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } mtx_state_e;

endpackage

// File: rtl/matrix_result_fifo.sv
// Two-entry word FIFO between the packer and the result RAM.
// The head entry is always presented on dout; clr empties it in one edge.
// A push while full is only accepted when a pop happens in the same cycle.
module matrix_result_fifo #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wp_q, wp_d;
    logic         rp_q, rp_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push_ok, pop_ok;

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign dout  = mem_q[rp_q];

    // Next pointers, occupancy and storage from push/pop/clear.
    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        if (clr) begin
            wp_d  = 1'b0;
            rp_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push_ok) begin
                mem_d[wp_q] = din;
                wp_d        = ~wp_q;
            end
            if (pop_ok) begin
                rp_d = ~rp_q;
            end
            if (push_ok && !pop_ok) begin
                cnt_d = cnt_q + 2'd1;
            end else if (pop_ok && !push_ok) begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    // FIFO state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matrix_result_packer.sv
// Packs per-lane pipe results into WORDS-element RAM words, in arrival order,
// and writes them to the result RAM at an incrementing address.
// RAM handshake: a word moves when wr_en and wr_rdy are both high on a rising
// edge; wr_en stays high with stable wr_adr/wr_dat until that happens.
module matrix_result_packer
    import matrix_pkg::*;
#(
    parameter int LANES = MTX_LANES,
    parameter int DW    = MTX_DW,
    parameter int WORDS = MTX_WORDS,
    parameter int AW    = MTX_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         num_elem,
    input  logic [LANES-1:0]    in_en,
    input  logic [LANES*DW-1:0] in_dat,
    output logic                wr_en,
    input  logic                wr_rdy,
    output logic [AW-1:0]       wr_adr,
    output logic [WORDS*DW-1:0] wr_dat,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [1:0]          STATE
);

    // Staging must hold a nearly full word plus one full lane beat.
    localparam int SW = WORDS + LANES - 1;
    localparam int FW = $clog2(SW + 1);
    localparam int WW = WORDS * DW;

    mtx_state_e     state_q, state_d;
    logic [15:0]    num_q, num_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic [DW-1:0]  stage_q [SW];
    logic [DW-1:0]  stage_d [SW];
    logic [DW-1:0]  stg [SW];
    logic [AW-1:0]  adr_q, adr_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;
    logic           push, fifo_clr, fifo_full, fifo_empty, xfer;
    logic [WW-1:0]  push_word;
    int             nvalid, take, remain, nfill;

    assign wr_en  = !fifo_empty;
    assign xfer   = wr_en && wr_rdy;
    assign wr_adr = adr_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign STATE  = state_q;

    // FSM next state, element accounting, staging append/shift and word push.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        stage_d   = stage_q;
        stg       = stage_q;
        adr_d     = adr_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        fifo_clr  = 1'b0;
        push      = 1'b0;
        push_word = '0;
        nvalid    = 0;
        take      = 0;
        nfill     = int'(fill_q);
        remain    = int'(num_q) - int'(cnt_q);

        for (int j = 0; j < LANES; j++) begin
            if (in_en[j]) nvalid = nvalid + 1;
        end

        if (xfer) adr_d = adr_q + 1'b1;

        if (start) begin
            // Start from any state aborts whatever is in flight.
            state_d  = ST_RUN;
            num_d    = num_elem;
            cnt_d    = '0;
            fill_d   = '0;
            stage_d  = '{default: '0};
            adr_d    = '0;
            ovf_d    = 1'b0;
            fifo_clr = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cnt_q == num_q) begin
                        // All elements seen: emit any partial word zero-padded.
                        state_d = ST_FLUSH;
                        if (fill_q != '0) begin
                            push = 1'b1;
                            for (int k = 0; k < WORDS; k++) begin
                                if (k < int'(fill_q)) push_word[k*DW +: DW] = stage_q[k];
                            end
                        end
                        fill_d  = '0;
                        stage_d = '{default: '0};
                    end else begin
                        // Clip the beat so the run never exceeds num_elem.
                        take = (nvalid < remain) ? nvalid : remain;
                        for (int p = 0; p < SW; p++) begin
                            for (int j = 0; j < LANES; j++) begin
                                if (j < take && p == int'(fill_q) + j) stg[p] = in_dat[j*DW +: DW];
                            end
                        end
                        nfill = int'(fill_q) + take;
                        cnt_d = cnt_q + 16'(take);
                        if (nfill >= WORDS) begin
                            push = 1'b1;
                            for (int k = 0; k < WORDS; k++) push_word[k*DW +: DW] = stg[k];
                            stage_d = '{default: '0};
                            for (int p = 0; p < SW - WORDS; p++) stage_d[p] = stg[p + WORDS];
                            nfill = nfill - WORDS;
                        end else begin
                            stage_d = stg;
                        end
                        fill_d = FW'(nfill);
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
            if (push && fifo_full && !xfer) ovf_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            stage_q <= '{default: '0};
            adr_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            stage_q <= stage_d;
            adr_q   <= adr_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    matrix_result_fifo #(.W(WW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (push),
        .pop   (xfer),
        .din   (push_word),
        .dout  (wr_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
